// File: rtl/inverse_quant_qt_qscale.sv
// Rebuilds one 8x8 coefficient block as (level * qscale * qmat[r][c]) >>> 2, saturated.
// Latency: 3 cycles accept-to-write, OUT_VALID 4 cycles after the index-63 accept.
// Backpressure: IN_READY drops from last accept until the output block is handshaken.
module inverse_quant_qt_qscale #(
   parameter int DATA_W = 32
) (
   input  logic                           CLOCK,
   input  logic                           RESET,
   input  logic                           IN_VALID,
   output logic                           IN_READY,
   input  logic [DATA_W-1:0]              IN_DATA,
   input  logic [DATA_W-1:0]              QSCALE,
   input  logic [7:0][7:0][DATA_W-1:0]    QMAT,
   output logic                           OUT_VALID,
   input  logic                           OUT_READY,
   output logic [7:0][7:0][DATA_W-1:0]    OUT_DATA
);

   localparam int PW = 2*DATA_W + 1;
   localparam logic signed [PW-1:0] SMAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [PW-1:0] SMIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, FILL, DRAIN, HOLD} state_t;

   state_t                state, state_nxt;
   logic [5:0]            index;
   logic                  accept;
   logic [DATA_W-1:0]     qscale_lat;

   // capture stage: level, index and the qscale that applies to this block
   logic                  v0;
   logic [DATA_W-1:0]     s0_lvl;
   logic [DATA_W-1:0]     s0_qs;
   logic [5:0]            s0_idx;
   // S1: combined quantiser step
   logic                  v1;
   logic [DATA_W-1:0]     s1_lvl;
   logic [DATA_W-1:0]     s1_q;
   logic [5:0]            s1_idx;
   // S2: full-precision signed product
   logic                  v2;
   logic signed [PW-1:0]  s2_p;
   logic [5:0]            s2_idx;
   // S3: shift and clamp, combinational into the output buffer write
   logic signed [PW-1:0]  s3_shift;
   logic [DATA_W-1:0]     s3_sat;
   logic                  pipe_empty;

   assign accept     = IN_VALID && IN_READY;
   assign pipe_empty = !v0 && !v1 && !v2;

   // state register
   always_ff @(posedge CLOCK) begin
      if (!RESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state: fill 64 levels, wait for the pipe to empty, hold until taken
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = FILL;
         FILL:  if (accept && index == 6'd63) state_nxt = DRAIN;
         DRAIN: if (pipe_empty) state_nxt = HOLD;
         HOLD:  if (OUT_READY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs decoded from state; ready is forced low while reset is asserted
   always_comb begin
      IN_READY  = RESET && (state == IDLE || state == FILL);
      OUT_VALID = (state == HOLD);
   end

   // raster index and per-block qscale latch
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         index      <= '0;
         qscale_lat <= '0;
      end else if (accept) begin
         index <= index + 6'd1;
         if (index == 6'd0) qscale_lat <= QSCALE;
      end
   end

   // multiply pipeline; valids flush on reset so a partial block never lands
   always_ff @(posedge CLOCK) begin
      if (!RESET) begin
         v0     <= 1'b0;
         v1     <= 1'b0;
         v2     <= 1'b0;
         s0_lvl <= '0;
         s0_qs  <= '0;
         s0_idx <= '0;
         s1_lvl <= '0;
         s1_q   <= '0;
         s1_idx <= '0;
         s2_p   <= '0;
         s2_idx <= '0;
      end else begin
         v0     <= accept;
         s0_lvl <= IN_DATA;
         s0_qs  <= (index == 6'd0) ? QSCALE : qscale_lat;
         s0_idx <= index;
         v1     <= v0;
         s1_lvl <= s0_lvl;
         s1_q   <= s0_qs * QMAT[s0_idx[5:3]][s0_idx[2:0]];
         s1_idx <= s0_idx;
         v2     <= v1;
         s2_p   <= $signed({{(DATA_W+1){s1_lvl[DATA_W-1]}}, s1_lvl})
                 * $signed({{(DATA_W+1){1'b0}}, s1_q});
         s2_idx <= s1_idx;
      end
   end

   // floor divide by 4, then clamp to the signed output range
   always_comb begin
      s3_shift = s2_p >>> 2;
      s3_sat   = s3_shift[DATA_W-1:0];
      if (s3_shift > SMAX)      s3_sat = SMAX[DATA_W-1:0];
      else if (s3_shift < SMIN) s3_sat = SMIN[DATA_W-1:0];
   end

   // output block buffer; contents persist after handshake until overwritten
   always_ff @(posedge CLOCK) begin
      if (!RESET)  OUT_DATA <= '0;
      else if (v2) OUT_DATA[s2_idx[5:3]][s2_idx[2:0]] <= s3_sat;
   end

endmodule

// File: tb/tb_inverse_quant_qt_qscale.sv
module tb_inverse_quant_qt_qscale;

   logic                    CLOCK = 1'b0;
   logic                    RESET;
   logic                    IN_VALID;
   logic                    IN_READY;
   logic [31:0]             IN_DATA;
   logic [31:0]             QSCALE;
   logic [7:0][7:0][31:0]   QMAT;
   logic                    OUT_VALID;
   logic                    OUT_READY;
   logic [7:0][7:0][31:0]   OUT_DATA;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] lv [64];
   logic [31:0] ex [64];

   inverse_quant_qt_qscale #(.DATA_W(32)) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_DATA   (IN_DATA),
      .QSCALE    (QSCALE),
      .QMAT      (QMAT),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DATA  (OUT_DATA)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_block(input string tag);
      for (int i = 0; i < 64; i++)
         check($sformatf("%s[%0d]", tag, i), OUT_DATA[i/8][i%8], ex[i]);
   endtask

   task automatic set_qmat(input logic [31:0] v);
      for (int i = 0; i < 64; i++) QMAT[i/8][i%8] = v;
   endtask

   // feeds n levels from lv; called and returning on a negedge
   task automatic feed(input int n, input bit gaps, input logic [31:0] qs);
      int  sent = 0;
      int  cyc  = 0;
      bit  acc;
      QSCALE = qs;
      while (sent < n && cyc < 1000) begin
         IN_VALID = (gaps && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
         IN_DATA  = lv[sent];
         acc = IN_VALID && IN_READY;
         @(negedge CLOCK);
         cyc++;
         if (acc) begin
            sent++;
            if (sent == 1 && gaps) QSCALE = 32'hDEAD_BEEF;
         end
      end
      IN_VALID = 1'b0;
      check("feed_count", sent, n);
   endtask

   // counts edges from the last accept edge until OUT_VALID appears
   task automatic wait_out(input int exp_lat);
      int c = 0;
      while (!OUT_VALID && c < 20) begin
         @(negedge CLOCK);
         c++;
      end
      check("out_latency", c, exp_lat);
   endtask

   task automatic handshake(input string tag);
      OUT_READY = 1'b1;
      @(negedge CLOCK);
      OUT_READY = 1'b0;
      check({tag, "_ovalid_after_hs"}, OUT_VALID, 1'b0);
      check({tag, "_iready_after_hs"}, IN_READY, 1'b1);
   endtask

   initial begin
      bit seen;
      RESET     = 1'b0;
      IN_VALID  = 1'b0;
      IN_DATA   = '0;
      QSCALE    = '0;
      QMAT      = '0;
      OUT_READY = 1'b0;

      // 1: reset held three cycles
      repeat (3) @(negedge CLOCK);
      check("rst_ovalid", OUT_VALID, 1'b0);
      check("rst_iready", IN_READY, 1'b0);
      check("rst_odata_00", OUT_DATA[0][0], 32'h0);
      check("rst_odata_77", OUT_DATA[7][7], 32'h0);
      RESET = 1'b1;
      #1;
      check("rel_iready", IN_READY, 1'b1);
      @(negedge CLOCK);

      // 2a: level 1, qscale 1, qmat 4 -> 1
      set_qmat(32'd4);
      for (int i = 0; i < 64; i++) begin lv[i] = 32'd1; ex[i] = 32'd1; end
      feed(64, 1'b0, 32'd1);
      check("t2a_ovalid_early", OUT_VALID, 1'b0);
      wait_out(4);
      check("t2a_iready_hold", IN_READY, 1'b0);
      check_block("t2a");
      handshake("t2a");
      check("t2a_data_kept", OUT_DATA[3][5], 32'd1);

      // 2b: level -5, qscale 2, qmat 2 -> -20 >>> 2 = -5
      set_qmat(32'd2);
      for (int i = 0; i < 64; i++) begin lv[i] = -32'sd5; ex[i] = -32'sd5; end
      feed(64, 1'b0, 32'd2);
      wait_out(4);
      check_block("t2b");
      handshake("t2b");

      // 3: floor rounding of the >>> 2, qscale 1, qmat 1
      set_qmat(32'd1);
      for (int i = 0; i < 64; i++) begin lv[i] = 32'd8; ex[i] = 32'd2; end
      lv[0] = -32'sd3; ex[0] = 32'hFFFF_FFFF;
      lv[1] = 32'd3;   ex[1] = 32'd0;
      lv[2] = 32'd0;   ex[2] = 32'd0;
      lv[3] = -32'sd4; ex[3] = 32'hFFFF_FFFF;
      lv[4] = 32'd7;   ex[4] = 32'd1;
      lv[5] = -32'sd1; ex[5] = 32'hFFFF_FFFF;
      feed(64, 1'b0, 32'd1);
      wait_out(4);
      check_block("t3");
      handshake("t3");

      // 4: saturation with qscale 8 (effective x2), zero qmat entry
      set_qmat(32'd1);
      QMAT[7][7] = 32'd0;
      for (int i = 0; i < 64; i++) begin lv[i] = 32'd1; ex[i] = 32'd2; end
      lv[0]  = 32'h7FFF_FFFF; ex[0] = 32'h7FFF_FFFF;
      lv[1]  = 32'h8000_0000; ex[1] = 32'h8000_0000;
      lv[2]  = 32'h1000_0000; ex[2] = 32'h2000_0000;
      lv[3]  = 32'h4000_0000; ex[3] = 32'h7FFF_FFFF;
      lv[4]  = 32'hC000_0000; ex[4] = 32'h8000_0000;
      ex[63] = 32'd0;
      feed(64, 1'b0, 32'd8);
      wait_out(4);
      check_block("t4");
      handshake("t4");

      // 5: input gaps, qscale changed after idx0, consumer stalls 10 cycles
      set_qmat(32'd4);
      for (int i = 0; i < 64; i++) begin
         lv[i] = 32'(i - 32);
         ex[i] = 32'((i - 32) * 3);
      end
      feed(64, 1'b1, 32'd3);
      wait_out(4);
      IN_VALID = 1'b1;
      IN_DATA  = 32'h0BAD_0BAD;
      for (int k = 0; k < 10; k++) begin
         check("t5_stall_iready", IN_READY, 1'b0);
         check("t5_stall_ovalid", OUT_VALID, 1'b1);
         check("t5_stall_d0", OUT_DATA[0][0], ex[0]);
         check("t5_stall_d63", OUT_DATA[7][7], ex[63]);
         @(negedge CLOCK);
      end
      IN_VALID = 1'b0;
      check_block("t5");
      handshake("t5");

      // 6: reset after 30 accepts discards the block
      for (int i = 0; i < 64; i++) begin
         QMAT[i/8][i%8] = 32'(i + 1);
         lv[i] = 32'd1;
         ex[i] = 32'(i + 1);
      end
      feed(30, 1'b0, 32'd4);
      RESET = 1'b0;
      @(negedge CLOCK);
      RESET = 1'b1;
      check("t6_rst_d00", OUT_DATA[0][0], 32'h0);
      check("t6_rst_d77", OUT_DATA[7][7], 32'h0);
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         seen |= OUT_VALID;
         @(negedge CLOCK);
      end
      check("t6_no_ovalid", seen, 1'b0);
      check("t6_iready", IN_READY, 1'b1);
      feed(64, 1'b0, 32'd4);
      wait_out(4);
      check_block("t6");
      handshake("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
